// File: rtl/testing_3_if.sv
// Operand/result bundle for the bit-serial adder: operands flow master->slave,
// registered sum/carry and the done pulse flow back.
interface testing_3_if;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic [31:0] sum;
   logic        carry;
   logic        done;

   modport master (output a, output b, output cin,
                   input  sum, input carry, input done);
   modport slave  (input  a, input b, input cin,
                   output sum, output carry, output done);
endinterface

// File: rtl/testing_3.sv
// Free-running 32-bit bit-serial adder: LOAD, 32 SHIFT edges through one
// full-adder cell, then DONE publishes {carry, sum} and pulses done.
module testing_3 (
   input  logic        clock,
   input  logic        reset,
   testing_3_if.slave  bus
);
   typedef enum logic [1:0] {LOAD, SHIFT, DONE} state_t;

   state_t      state_q;
   logic [31:0] opa_q, opb_q, res_q, sum_q;
   logic        c_q, carry_q, done_q;
   logic [4:0]  cnt_q;
   logic        s_d, c_d;

   // The single full-adder cell shared by every bit position.
   always_comb begin
      s_d = opa_q[0] ^ opb_q[0] ^ c_q;
      c_d = (opa_q[0] & opb_q[0]) | (opa_q[0] & c_q) | (opb_q[0] & c_q);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= LOAD;
         opa_q   <= '0;
         opb_q   <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            LOAD: begin
               opa_q   <= bus.a;
               opb_q   <= bus.b;
               c_q     <= bus.cin;
               cnt_q   <= '0;
               res_q   <= '0;
               state_q <= SHIFT;
            end
            SHIFT: begin
               c_q   <= c_d;
               opa_q <= {1'b0, opa_q[31:1]};
               opb_q <= {1'b0, opb_q[31:1]};
               // Entering at the MSB leaves bit 0 at position 0 after 32 shifts.
               res_q <= {s_d, res_q[31:1]};
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= DONE;
            end
            DONE: begin
               sum_q   <= res_q;
               carry_q <= c_q;
               done_q  <= 1'b1;
               state_q <= LOAD;
            end
            default: state_q <= LOAD;
         endcase
      end
   end

   assign bus.sum   = sum_q;
   assign bus.carry = carry_q;
   assign bus.done  = done_q;
endmodule

// File: tb/tb_testing_3.sv
// Directed + random bench for testing_3: expected {carry,sum} queued at each
// LOAD, popped and compared when done pulses; also checks the 34-cycle period.
module tb_testing_3;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   testing_3_if bus ();
   testing_3 dut (.clock(clock), .reset(reset), .bus(bus));

   int errors = 0;
   int checks = 0;
   logic [32:0] exp_q[$];

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entered at a negedge just before a LOAD edge; returns at the negedge after DONE.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input bit scramble);
      logic [32:0] snap, exp;
      int  n;
      bit  stable;
      bus.a   = a;
      bus.b   = b;
      bus.cin = ci;
      exp_q.push_back({1'b0, a} + {1'b0, b} + {32'd0, ci});
      snap   = {bus.carry, bus.sum};
      stable = 1'b1;
      n      = 0;
      do begin
         @(posedge clock);
         @(negedge clock);
         n++;
         if (scramble && n == 6) begin
            bus.a   = $urandom;
            bus.b   = $urandom;
            bus.cin = 1'($urandom_range(0, 1));
         end
         if (!bus.done && ({bus.carry, bus.sum} !== snap)) stable = 1'b0;
      end while (!bus.done && n < 40);
      chk({tag, "/period"}, 33'(n), 33'd34);
      chk({tag, "/hold"}, {32'd0, stable}, 33'd1);
      exp = exp_q.pop_front();
      chk({tag, "/result"}, {bus.carry, bus.sum}, exp);
   endtask

   initial begin
      bus.a   = 32'd0;
      bus.b   = 32'd0;
      bus.cin = 1'b0;
      reset   = 1'b1;
      repeat (5) begin
         @(posedge clock);
         @(negedge clock);
         chk("rst/sum", {1'b0, bus.sum}, 33'd0);
         chk("rst/carry", {32'd0, bus.carry}, 33'd0);
         chk("rst/done", {32'd0, bus.done}, 33'd0);
      end
      reset = 1'b0;
      run_op("add500", 32'd500, 32'd600, 1'b0, 1'b0);
      run_op("add1500a", 32'd1500, 32'd11600, 1'b1, 1'b0);
      run_op("add1500b", 32'd1500, 32'd11600, 1'b1, 1'b0);
      run_op("scramble", 32'd50000, 32'd60020, 1'b0, 1'b1);
      run_op("ones_cin", 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
      run_op("ones_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op("cin_only", 32'd0, 32'd0, 1'b1, 1'b0);

      // Abort: reset sampled at the 10th SHIFT edge (LOAD + 10 edges later).
      bus.a   = 32'h1234_5678;
      bus.b   = 32'h0FED_CBA9;
      bus.cin = 1'b1;
      repeat (10) begin
         @(posedge clock);
         @(negedge clock);
      end
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      chk("abort/sum", {1'b0, bus.sum}, 33'd0);
      chk("abort/carry", {32'd0, bus.carry}, 33'd0);
      chk("abort/done", {32'd0, bus.done}, 33'd0);
      repeat (2) begin
         @(posedge clock);
         @(negedge clock);
         chk("abort/hold_done", {32'd0, bus.done}, 33'd0);
      end
      reset = 1'b0;
      run_op("post_abort", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);

      for (int i = 0; i < 1000; i++)
         run_op("rnd", $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
